// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow pulses and synchronous flush. Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       rd_en,
    input  logic                       flush,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr_nxt;
    logic [AW-1:0]         rd_ptr_nxt;
    logic [CW-1:0]         count_nxt;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ovf_nxt;
    logic                  unf_nxt;

    // Accept decisions; a read frees the slot a simultaneous write into a full FIFO needs.
    always_comb begin
        rd_acc     = 1'b0;
        wr_acc     = 1'b0;
        ovf_nxt    = 1'b0;
        unf_nxt    = 1'b0;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            rd_acc     = rd_en && !empty;
            wr_acc     = wr_en && (!full || rd_acc);
            ovf_nxt    = wr_en && !wr_acc;
            unf_nxt    = rd_en && !rd_acc;
            wr_ptr_nxt = wr_ptr + AW'(wr_acc);
            rd_ptr_nxt = rd_ptr + AW'(rd_acc);
            count_nxt  = count + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // Pointers, count and flags; flags derive from the next count so they move with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_THRESH));
            almost_empty <= (count_nxt <= CW'(AE_THRESH));
            overflow     <= ovf_nxt;
            underflow    <= unf_nxt;
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; rd_en only pops.
    assign dout = mem[rd_ptr];
`else
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rd_ptr];
        end
    end

    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_sync_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFT   = 14;
    localparam int unsigned AET   = 2;
    localparam int unsigned CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic          flush;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    sync_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AFT),
        .AE_THRESH  (AET)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .flush        (flush),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] mdout = '0;
    logic          movf  = 1'b0;
    logic          munf  = 1'b0;

    logic [CW+5:0] stat;
    assign stat = {count, full, empty, almost_full, almost_empty, overflow, underflow};

    function automatic logic [CW+5:0] exp_stat();
        int n;
        n = q.size();
        return {CW'(n), n == DEPTH, n == 0, n >= AFT, n <= AET, movf, munf};
    endfunction

    // Drive one cycle of requests and advance the model; returns #1 after the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        logic rok;
        logic wok;
        @(negedge clk);
        wr_en = w; din = d; rd_en = r; flush = f;
        @(posedge clk);
        if (f) begin
            q.delete();
            movf = 1'b0;
            munf = 1'b0;
        end else begin
            rok = r && (q.size() != 0);
            wok = w && ((q.size() < DEPTH) || rok);
            if (rok) mdout = q.pop_front();
            if (wok) q.push_back(d);
            movf = w && !wok;
            munf = r && !rok;
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; din = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (stat !== {CW'(0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errs++; $display("FAIL reset_flags: got %h want %h", stat, {CW'(0), 6'b010100});
        end
`ifndef FIFO_FWFT_EN
        vectors++;
        if (dout !== 8'h00) begin
            errs++; $display("FAIL reset_dout: got %h want 00", dout);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            vectors++;
            if (count !== CW'(i) || almost_full !== (i >= 14) || full !== (i == 16) ||
                overflow !== 1'b0 || empty !== 1'b0) begin
                errs++;
                $display("FAIL fill_%0d: got cnt=%0d af=%b f=%b ovf=%b e=%b want cnt=%0d af=%b f=%b ovf=0 e=0",
                         i, count, almost_full, full, overflow, empty, i, i >= 14, i == 16);
            end
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b1 || count !== CW'(16) || full !== 1'b1) begin
            errs++; $display("FAIL ovf_pulse: got ovf=%b cnt=%0d want ovf=1 cnt=16", overflow, count);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        vectors++;
        if (overflow !== 1'b0 || count !== CW'(16)) begin
            errs++; $display("FAIL ovf_clear: got ovf=%b cnt=%0d want ovf=0 cnt=16", overflow, count);
        end
        for (int i = 1; i <= 16; i++) begin
`ifdef FIFO_FWFT_EN
            vectors++;
            if (dout !== 8'(i)) begin
                errs++; $display("FAIL ovf_drain_%0d: got %h want %h", i, dout, 8'(i));
            end
            step(1'b0, '0, 1'b1, 1'b0);
`else
            step(1'b0, '0, 1'b1, 1'b0);
            vectors++;
            if (dout !== 8'(i)) begin
                errs++; $display("FAIL ovf_drain_%0d: got %h want %h", i, dout, 8'(i));
            end
`endif
        end
        vectors++;
        if (empty !== 1'b1 || count !== CW'(0)) begin
            errs++; $display("FAIL ovf_empty: got e=%b cnt=%0d want e=1 cnt=0", empty, count);
        end
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] got;
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
        got = dout;
        step(1'b1, 8'h55, 1'b1, 1'b0);
`else
        step(1'b1, 8'h55, 1'b1, 1'b0);
        got = dout;
`endif
        vectors++;
        if (got !== 8'h01 || count !== CW'(16) || overflow !== 1'b0) begin
            errs++; $display("FAIL full_rw: got dout=%h cnt=%0d ovf=%b want dout=01 cnt=16 ovf=0", got, count, overflow);
        end
        for (int i = 1; i <= 16; i++) begin
`ifdef FIFO_FWFT_EN
            got = dout;
            step(1'b0, '0, 1'b1, 1'b0);
`else
            step(1'b0, '0, 1'b1, 1'b0);
            got = dout;
`endif
            vectors++;
            if (got !== ((i == 16) ? 8'h55 : 8'(i + 1))) begin
                errs++; $display("FAIL full_rw_rd_%0d: got %h want %h", i, got, (i == 16) ? 8'h55 : 8'(i + 1));
            end
        end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] prev;
        prev = dout;
        step(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (underflow !== 1'b1 || count !== CW'(0) || empty !== 1'b1) begin
            errs++; $display("FAIL unf_pulse: got unf=%b cnt=%0d want unf=1 cnt=0", underflow, count);
        end
`ifndef FIFO_FWFT_EN
        vectors++;
        if (dout !== prev) begin
            errs++; $display("FAIL unf_dout_hold: got %h want %h", dout, prev);
        end
`endif
        step(1'b0, '0, 1'b0, 1'b0);
        vectors++;
        if (underflow !== 1'b0) begin
            errs++; $display("FAIL unf_clear: got %b want 0", underflow);
        end
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        vectors++;
        if (underflow !== 1'b1 || count !== CW'(1) || empty !== 1'b0) begin
            errs++; $display("FAIL unf_wr_rd: got unf=%b cnt=%0d want unf=1 cnt=1", underflow, count);
        end
`ifdef FIFO_FWFT_EN
        vectors++;
        if (dout !== 8'h3C) begin
            errs++; $display("FAIL unf_readback: got %h want 3c", dout);
        end
        step(1'b0, '0, 1'b1, 1'b0);
`else
        step(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (dout !== 8'h3C) begin
            errs++; $display("FAIL unf_readback: got %h want 3c", dout);
        end
`endif
    endtask

    task automatic test_flush();
        logic [DW-1:0] prev;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        prev = dout;
        step(1'b1, 8'h99, 1'b1, 1'b1);
        vectors++;
        if (stat !== {CW'(0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errs++; $display("FAIL flush_flags: got %h want %h", stat, {CW'(0), 6'b010100});
        end
`ifndef FIFO_FWFT_EN
        vectors++;
        if (dout !== prev) begin
            errs++; $display("FAIL flush_dout_hold: got %h want %h", dout, prev);
        end
`endif
        step(1'b1, 8'hA5, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
        vectors++;
        if (dout !== 8'hA5) begin
            errs++; $display("FAIL flush_readback: got %h want a5", dout);
        end
        step(1'b0, '0, 1'b1, 1'b0);
`else
        step(1'b0, '0, 1'b1, 1'b0);
        vectors++;
        if (dout !== 8'hA5) begin
            errs++; $display("FAIL flush_readback: got %h want a5", dout);
        end
`endif
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (stat !== {CW'(0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errs++; $display("FAIL async_rst_flags: got %h want %h", stat, {CW'(0), 6'b010100});
        end
`ifndef FIFO_FWFT_EN
        vectors++;
        if (dout !== 8'h00) begin
            errs++; $display("FAIL async_rst_dout: got %h want 00", dout);
        end
`endif
        q.delete();
        mdout = '0; movf = 1'b0; munf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        vectors++;
`ifdef FIFO_FWFT_EN
        if (dout !== 8'h77) begin
            errs++; $display("FAIL fwft_head: got %h want 77", dout);
        end
`else
        if (dout !== 8'h00) begin
            errs++; $display("FAIL std_no_read_hold: got %h want 00", dout);
        end
`endif
    endtask

    task automatic test_random();
        logic w, r, f;
        for (int n = 0; n < 3000; n++) begin
            w = ($urandom_range(99) < 55);
            r = ($urandom_range(99) < 50);
            f = ($urandom_range(99) < 3);
            step(w, DW'($urandom), r, f);
            vectors++;
            if (stat !== exp_stat()) begin
                errs++; $display("FAIL rand_stat_%0d: got %h want %h", n, stat, exp_stat());
            end
`ifdef FIFO_FWFT_EN
            if (q.size() != 0) begin
                vectors++;
                if (dout !== q[0]) begin
                    errs++; $display("FAIL rand_dout_%0d: got %h want %h", n, dout, q[0]);
                end
            end
`else
            vectors++;
            if (dout !== mdout) begin
                errs++; $display("FAIL rand_dout_%0d: got %h want %h", n, dout, mdout);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Parametrised single-clock FIFO, the successor to the basic synchronous FIFO. It adds an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses and a synchronous flush. A compile-time first-word-fall-through read mode is also available. It sits between any two same-clock producer/consumer stages as the standard buffering primitive.

## Interface
- DATA_WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- flush  in  1  synchronous clear of contents
- dout  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH×DATA_WIDTH array; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is a separate register.
- Write accepted iff wr_en && (!full || rd_accepted). Read accepted iff rd_en && !empty.
- Full + wr_en + rd_en: both accepted, count unchanged. The read returns the old head; the write lands in the freed slot.
- Empty + wr_en + rd_en: write only, read rejected, underflow pulses.
- count next = count + wr_acc − rd_acc. All flags are registered and computed from the next count, so they are valid on the same edge as count.
- Rejected write (wr_en && full && !rd_en): data dropped, overflow=1 next cycle. Rejected read: underflow=1 next cycle. Pulses last exactly one cycle per rejected request.
- flush has highest priority. It sets pointers and count to 0 and flags to their reset values. Any wr_en/rd_en that cycle is ignored with no overflow/underflow. Memory contents are not cleared. dout holds in standard mode.
- Reset (rst_n=0, asynchronous): count=0, pointers=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0. Reset mid-operation discards all contents immediately.
- Memory array is not reset.

## Timing
- Write latency: data written on edge N is readable from edge N+1; empty deasserts after edge N.
- Standard read: dout is registered and loads mem[rd_ptr] on the accepting edge, valid from that edge until the next accepted read. dout holds when no read is accepted.
- Flags and count change only on clock edges, except under asynchronous reset.
- No combinational path from wr_en/rd_en/din to any output in standard mode.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - dout = mem[rd_ptr] combinationally; head word is visible whenever empty=0, before rd_en.
  - rd_en acts as pop/acknowledge.
  - dout is don't-care while empty=1.
  - Entry written at edge N is on dout after edge N.
- FIFO_FWFT_EN undefined: standard registered-read behaviour as above.
- Flags, count, error pulses and all accept rules are identical in both modes.

## Test plan
- Reset, then write 0x01..0x10 (DEPTH=16) on consecutive cycles -> count steps 1..16; almost_full rises at count=14; full=1 after the 16th write; overflow stays 0.
- With FIFO full, wr_en=1 din=0xEE for one cycle with rd_en=0 -> overflow pulses one cycle, count stays 16, subsequent reads return 0x01..0x10 and never 0xEE.
- Full FIFO, wr_en=rd_en=1 with din=0x55 -> read returns 0x01, count stays 16, 0x55 emerges as the 16th subsequent read (pointer wrap check).
- Empty FIFO, rd_en=1 -> underflow pulses once, count 0, dout unchanged. Empty with wr_en=rd_en=1 din=0x3C -> count=1, underflow pulse; next read returns 0x3C.
- Write 5 words, assert flush with wr_en=1 -> count=0, empty=1, almost_empty=1, no overflow; next write 0xA5 then read returns 0xA5.
- Write 3 words, drop rst_n mid-cycle -> all outputs take reset values before the next edge. Repeat under FIFO_FWFT_EN: after one write of 0x77, dout=0x77 without rd_en.
